maze_path_reverser: RTL and testbench

Downstream stage of the maze solver. Captures the solved path, which the solver emits goal-first as a burst of (x,y) pairs with no backpressure. Replays the path start-first over a valid/ready handshake, with path length and a failure indication for unsolvable mazes.

---
 rtl/maze_pkg.sv | 20 ++
 rtl/path_lifo.sv | 54 +++++
 rtl/maze_path_reverser.sv | 129 ++++++++++++
 tb/tb_maze_path_reverser.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze solver datapath.
package maze_pkg;

  localparam int unsigned MAZE_DIM  = 15;
  localparam int unsigned START_POS = 1;
  localparam int unsigned GOAL_POS  = 13;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
  } coord_t;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDrain,
    StFail
  } rev_state_e;

endpackage

// File: rtl/path_lifo.sv
// Register-array stack of path coordinates; exposes top and the entry beneath it.
module path_lifo
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = 169
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  logic       i_pop,
  input  coord_t     i_data,
  output coord_t     o_top,
  output coord_t     o_next,
  output logic [7:0] o_count,
  output logic       o_full,
  output logic       o_empty
);

  coord_t     r_mem [DEPTH];
  logic [7:0] r_count;
  logic [7:0] w_top_idx;
  logic [7:0] w_next_idx;
  logic       w_full;
  logic       w_empty;

  assign w_full     = (r_count == 8'(DEPTH));
  assign w_empty    = (r_count == 8'd0);
  assign w_top_idx  = w_empty ? 8'd0 : r_count - 8'd1;
  assign w_next_idx = (r_count > 8'd1) ? r_count - 8'd2 : 8'd0;

  // Storage needs no reset: only entries below r_count are ever observed.
  always_ff @(posedge clk) begin
    if (i_push && !w_full) begin
      r_mem[r_count] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= 8'd0;
    end else if (i_push && !w_full) begin
      r_count <= r_count + 8'd1;
    end else if (i_pop && !w_empty) begin
      r_count <= r_count - 8'd1;
    end
  end

  assign o_top   = r_mem[w_top_idx];
  assign o_next  = r_mem[w_next_idx];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/maze_path_reverser.sv
// Captures the goal-first solver burst and replays it start-first over valid/ready.
module maze_path_reverser
  import maze_pkg::*;
#(
  parameter int unsigned DEPTH = 169
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_not_valid,
  input  logic [3:0] in_x,
  input  logic [3:0] in_y,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_x,
  output logic [3:0] out_y,
  output logic       out_last,
  output logic       out_fail,
  output logic [7:0] out_len,
  output logic       err_overflow,
  output logic       err_drop
);

  rev_state_e r_state;
  coord_t     w_in;
  coord_t     w_top;
  coord_t     w_next;
  logic [7:0] w_count;
  logic       w_full;
  logic       w_empty;
  logic       w_push;
  logic       w_pop;

  assign w_in.x = in_x;
  assign w_in.y = in_y;

  assign w_push = in_valid &&
                  (((r_state == StIdle) && !in_not_valid) || ((r_state == StLoad) && !w_full));
  assign w_pop  = (r_state == StDrain) && out_ready;

  path_lifo #(
    .DEPTH(DEPTH)
  ) u_lifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_in),
    .o_top   (w_top),
    .o_next  (w_next),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      out_valid    <= 1'b0;
      out_x        <= 4'd0;
      out_y        <= 4'd0;
      out_last     <= 1'b0;
      out_fail     <= 1'b0;
      out_len      <= 8'd0;
      err_overflow <= 1'b0;
      err_drop     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (in_valid) begin
            err_overflow <= 1'b0;
            err_drop     <= 1'b0;
            if (in_not_valid) begin
              r_state   <= StFail;
              out_valid <= 1'b1;
              out_fail  <= 1'b1;
              out_last  <= 1'b1;
              out_x     <= 4'd0;
              out_y     <= 4'd0;
              out_len   <= 8'd0;
            end else begin
              r_state <= StLoad;
            end
          end
        end
        StLoad: begin
          if (in_valid) begin
            if (w_full) err_overflow <= 1'b1;
          end else begin
            // Burst ended: present the most recent push, which is the path start.
            r_state   <= StDrain;
            out_valid <= 1'b1;
            out_x     <= w_top.x;
            out_y     <= w_top.y;
            out_last  <= (w_count == 8'd1);
            out_len   <= w_count;
          end
        end
        StDrain: begin
          if (in_valid) err_drop <= 1'b1;
          if (out_ready) begin
            if (w_count <= 8'd1) begin
              r_state   <= StIdle;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_x     <= 4'd0;
              out_y     <= 4'd0;
            end else begin
              out_x    <= w_next.x;
              out_y    <= w_next.y;
              out_last <= (w_count == 8'd2);
            end
          end
        end
        StFail: begin
          if (in_valid) err_drop <= 1'b1;
          if (out_ready) begin
            r_state   <= StIdle;
            out_valid <= 1'b0;
            out_fail  <= 1'b0;
            out_last  <= 1'b0;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_maze_path_reverser.sv
// Directed bench for maze_path_reverser: replay order, stalls, fail beat, overflow, drop, reset.
module tb_maze_path_reverser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_not_valid = 1'b0;
  logic [3:0] in_x = 4'd0;
  logic [3:0] in_y = 4'd0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [3:0] out_x;
  logic [3:0] out_y;
  logic       out_last;
  logic       out_fail;
  logic [7:0] out_len;
  logic       err_overflow;
  logic       err_drop;

  int checks = 0;
  int errors = 0;

  maze_path_reverser #(
    .DEPTH(169)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_not_valid (in_not_valid),
    .in_x         (in_x),
    .in_y         (in_y),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_last     (out_last),
    .out_fail     (out_fail),
    .out_len      (out_len),
    .err_overflow (err_overflow),
    .err_drop     (err_drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] x, input logic [3:0] y);
    in_valid     = 1'b1;
    in_not_valid = 1'b0;
    in_x         = x;
    in_y         = y;
  endtask

  task automatic idle_in();
    in_valid     = 1'b0;
    in_not_valid = 1'b0;
    in_x         = 4'd0;
    in_y         = 4'd0;
  endtask

  task automatic beat(input string tag, input logic [3:0] x, input logic [3:0] y,
                      input logic last, input logic [7:0] len);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_x"}, 32'(out_x), 32'(x));
    check({tag, "_y"}, 32'(out_y), 32'(y));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    check({tag, "_fail"}, 32'(out_fail), 32'd0);
    check({tag, "_len"}, 32'(out_len), 32'(len));
  endtask

  // Loads the standard three-entry goal-first path and advances into DRAIN.
  task automatic load_short_path();
    send(4'd13, 4'd13); tick();
    send(4'd13, 4'd12); tick();
    send(4'd1, 4'd1);   tick();
    idle_in();
    check("gap_no_valid", 32'(out_valid), 32'd0);
    tick();
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_fail", 32'(out_fail), 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    check("rst_len", 32'(out_len), 32'd0);
    check("rst_ovf", 32'(err_overflow), 32'd0);
    check("rst_drop", 32'(err_drop), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Basic reversal at full throughput
    out_ready = 1'b1;
    load_short_path();
    beat("t1_b0", 4'd1, 4'd1, 1'b0, 8'd3);   tick();
    beat("t1_b1", 4'd13, 4'd12, 1'b0, 8'd3); tick();
    beat("t1_b2", 4'd13, 4'd13, 1'b1, 8'd3); tick();
    check("t1_done", 32'(out_valid), 32'd0);

    // Backpressure: ready 1,0,0,1,1
    load_short_path();
    out_ready = 1'b1; beat("t2_b0", 4'd1, 4'd1, 1'b0, 8'd3);    tick();
    out_ready = 1'b0; beat("t2_b1a", 4'd13, 4'd12, 1'b0, 8'd3); tick();
    beat("t2_b1b", 4'd13, 4'd12, 1'b0, 8'd3); tick();
    out_ready = 1'b1; beat("t2_b1c", 4'd13, 4'd12, 1'b0, 8'd3); tick();
    beat("t2_b2", 4'd13, 4'd13, 1'b1, 8'd3); tick();
    check("t2_done", 32'(out_valid), 32'd0);

    // Unsolvable maze
    out_ready    = 1'b0;
    in_valid     = 1'b1;
    in_not_valid = 1'b1;
    in_x         = 4'd7;
    in_y         = 4'd9;
    tick();
    idle_in();
    for (int k = 0; k < 3; k++) begin
      check("t3_valid", 32'(out_valid), 32'd1);
      check("t3_fail", 32'(out_fail), 32'd1);
      check("t3_last", 32'(out_last), 32'd1);
      check("t3_xy", 32'({out_x, out_y}), 32'd0);
      check("t3_len", 32'(out_len), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    check("t3_held", 32'(out_fail), 32'd1);
    tick();
    check("t3_done_valid", 32'(out_valid), 32'd0);
    check("t3_done_fail", 32'(out_fail), 32'd0);

    // Overflow: 170 beats into 169 entries; 170th is dropped
    out_ready = 1'b0;
    for (int i = 0; i < 170; i++) begin
      send(4'(i % 16), 4'((i / 16) % 16));
      tick();
    end
    idle_in();
    check("t4_ovf_set", 32'(err_overflow), 32'd1);
    tick();
    out_ready = 1'b1;
    for (int k = 0; k < 169; k++) begin
      int idx;
      idx = 168 - k;
      beat("t4_beat", 4'(idx % 16), 4'((idx / 16) % 16), (k == 168), 8'd169);
      tick();
    end
    check("t4_done", 32'(out_valid), 32'd0);
    check("t4_ovf_sticky", 32'(err_overflow), 32'd1);

    // Drop during DRAIN; also overflow cleared by new burst
    out_ready = 1'b0;
    send(4'd13, 4'd13); tick();
    check("t5_ovf_clr", 32'(err_overflow), 32'd0);
    send(4'd13, 4'd12); tick();
    send(4'd1, 4'd1);   tick();
    idle_in();          tick();
    check("t5_drop_pre", 32'(err_drop), 32'd0);
    send(4'd5, 4'd5);   tick();
    idle_in();
    check("t5_drop_set", 32'(err_drop), 32'd1);
    out_ready = 1'b1;
    beat("t5_b0", 4'd1, 4'd1, 1'b0, 8'd3);   tick();
    beat("t5_b1", 4'd13, 4'd12, 1'b0, 8'd3); tick();
    beat("t5_b2", 4'd13, 4'd13, 1'b1, 8'd3); tick();
    check("t5_done", 32'(out_valid), 32'd0);

    // Reset mid-DRAIN, then a fresh burst
    send(4'd13, 4'd13); tick();
    check("t6_drop_clr", 32'(err_drop), 32'd0);
    send(4'd13, 4'd12); tick();
    send(4'd1, 4'd1);   tick();
    idle_in();          tick();
    beat("t6_b0", 4'd1, 4'd1, 1'b0, 8'd3);   tick();
    beat("t6_b1", 4'd13, 4'd12, 1'b0, 8'd3);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_len", 32'(out_len), 32'd0);
    check("t6_rst_xy", 32'({out_x, out_y}), 32'd0);
    check("t6_rst_last", 32'(out_last), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    send(4'd2, 4'd3); tick();
    send(4'd4, 4'd5); tick();
    idle_in();        tick();
    beat("t6_n0", 4'd4, 4'd5, 1'b0, 8'd2); tick();
    beat("t6_n1", 4'd2, 4'd3, 1'b1, 8'd2); tick();
    check("t6_done", 32'(out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
